dmac_desc_engine: RTL and testbench

//  DMA channel engine sitting directly downstream of the 16-entry descriptor FIFO (32-bit words).

---
 rtl/dmac_desc_engine.sv | 167 ++++++++++++++++
 tb/tb_dmac_desc_engine.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_desc_engine.sv
// DMA channel engine: pops {SRC, DST, SIZE} descriptors from the descriptor FIFO and copies
// SIZE words from SRC to DST over a single-master bus, one read then one write per word.
// Latency: 6 cycles fetch (no retries) to first read; >= 2 cycles per word; done 1 cycle after last write.
// Backpressure: bus requests hold stable until m_grant; FIFO pops retried on err / no response.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   en                           gates starting a new descriptor (checked only in IDLE)
//   fifo_rd_en / fifo_dout /     FIFO pop pulse, read data, pop accepted, pop refused, occupancy
//   fifo_rd_ack / fifo_rd_err /
//   fifo_data_count
//   m_req / m_wr / m_addr /      bus request, direction, word address, write data, read data,
//   m_wdata / m_rdata / m_grant  grant (transfer completes on m_req & m_grant)
//   busy / done / rem_cnt        not-idle, per-descriptor completion pulse, words left to copy
module dmac_desc_engine #(
    parameter int ADDR_W = 8,
    parameter int SIZE_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    output logic              fifo_rd_en,
    input  logic [31:0]       fifo_dout,
    input  logic              fifo_rd_ack,
    input  logic              fifo_rd_err,
    input  logic [4:0]        fifo_data_count,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    input  logic              m_grant,
    output logic              busy,
    output logic              done,
    output logic [SIZE_W-1:0] rem_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        POP_WAIT,
        RD,
        WR,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        idx_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [31:0]       data_q;
    logic [SIZE_W-1:0] rem_q;

    // A refused pop and a pop with no response are handled identically (retry the
    // same word), so fifo_rd_err carries no extra information; upper FIFO bits
    // beyond the address/size fields are don't-care.
    logic unused_inputs;
    assign unused_inputs = ^{fifo_dout, fifo_rd_err};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // Only start when the whole descriptor is already in the FIFO.
                if (en && (fifo_data_count >= 5'd3)) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = POP_WAIT;
            end
            POP_WAIT: begin
                if (fifo_rd_ack) begin
                    if (idx_q == 2'd2) begin
                        state_d = (fifo_dout[SIZE_W-1:0] != '0) ? RD : DONE;
                    end else begin
                        state_d = POP;
                    end
                end else begin
                    state_d = POP;
                end
            end
            RD: begin
                if (m_grant) begin
                    state_d = WR;
                end
            end
            WR: begin
                if (m_grant) begin
                    // Remaining count is about to drop from 1 to 0.
                    state_d = (rem_q == {{(SIZE_W-1){1'b0}}, 1'b1}) ? DONE : RD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q  <= 2'd0;
            src_q  <= '0;
            dst_q  <= '0;
            data_q <= '0;
            rem_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    idx_q <= 2'd0;
                    rem_q <= '0;
                end
                POP_WAIT: begin
                    if (fifo_rd_ack) begin
                        case (idx_q)
                            2'd0:    src_q <= fifo_dout[ADDR_W-1:0];
                            2'd1:    dst_q <= fifo_dout[ADDR_W-1:0];
                            default: rem_q <= fifo_dout[SIZE_W-1:0];
                        endcase
                        if (idx_q != 2'd2) begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                RD: begin
                    if (m_grant) begin
                        data_q <= m_rdata;
                    end
                end
                WR: begin
                    if (m_grant) begin
                        // Addresses wrap silently at the bus width.
                        src_q <= src_q + 1'b1;
                        dst_q <= dst_q + 1'b1;
                        rem_q <= rem_q - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are decoded from registered state only, so m_grant never reaches m_req
    // combinationally and requests stay stable through a stall.
    assign fifo_rd_en = (state_q == POP);
    assign m_req      = (state_q == RD) || (state_q == WR);
    assign m_wr       = (state_q == WR);
    assign m_addr     = (state_q == RD) ? src_q : ((state_q == WR) ? dst_q : '0);
    assign m_wdata    = (state_q == WR) ? data_q : 32'd0;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign rem_cnt    = rem_q;

endmodule

// File: tb/tb_dmac_desc_engine.sv
// Bench for dmac_desc_engine: table of descriptors plus random ones, checked against a
// word-by-word copy model of memory and an expected bus-transaction list.
// FIFO and bus are modelled as responders; a reset-mid-read sequence finishes the run.
module tb_dmac_desc_engine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        fifo_rd_en;
    logic [31:0] fifo_dout;
    logic        fifo_rd_ack;
    logic        fifo_rd_err;
    logic [4:0]  fifo_data_count;
    logic        m_req;
    logic        m_wr;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_grant;
    logic        busy;
    logic        done;
    logic [15:0] rem_cnt;

    always #5 clk = ~clk;

    dmac_desc_engine #(.ADDR_W(8), .SIZE_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .en(en),
        .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_rd_ack(fifo_rd_ack),
        .fifo_rd_err(fifo_rd_err), .fifo_data_count(fifo_data_count),
        .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_grant(m_grant),
        .busy(busy), .done(done), .rem_cnt(rem_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Memory (owned by the monitor) and the reference copy (owned by the main sequence).
    logic [31:0] mem [256];
    logic [31:0] model_mem [256];
    assign m_rdata = mem[m_addr];

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        int          rem;
    } txn_t;
    txn_t exp_arr [512];
    int   exp_wr = 0;
    int   exp_rd = 0;

    typedef struct {
        logic [7:0]  src;
        logic [7:0]  dst;
        logic [15:0] size;
        int          exp_pops;
        int          exp_txns;
        bit          faults;
        bit          drop_en;
        bit          rand_grant;
    } vec_t;
    vec_t vecs [9];

    // FIFO contents pushed by the main sequence, consumed by the responder.
    logic [31:0] wbuf [64];
    int          n_pushed  = 0;
    int          fault_pop = -10;
    bit          rand_mode = 1'b0;

    int pops  = 0;
    int dones = 0;
    int txns  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: sampled mid-cycle, away from the active edge.
    bit          mem_init   = 1'b0;
    bit          prev_stall = 1'b0;
    logic [41:0] prev_bus;
    txn_t        t;
    always @(negedge clk) begin
        if (!mem_init) begin
            mem_init = 1'b1;
            for (int i = 0; i < 256; i++) mem[i] = $urandom;
            mem[8'h10] = 32'hAAAA_0001;
            mem[8'h11] = 32'hBBBB_0002;
            mem[8'h12] = 32'hCCCC_0003;
        end
        if (reset_n) begin
            if (fifo_rd_en) pops++;
            if (done) dones++;
            if (prev_stall) begin
                checks++;
                if ({m_req, m_wr, m_addr, m_wdata} !== prev_bus) begin
                    errors++;
                    $display("FAIL stall_hold actual=%0h required=%0h",
                             {m_req, m_wr, m_addr, m_wdata}, prev_bus);
                end
            end
            if (m_req && m_grant) begin
                txns++;
                checks++;
                if (exp_rd >= exp_wr) begin
                    errors++;
                    $display("FAIL bus_txn actual wr=%0d addr=%0h required none", m_wr, m_addr);
                end else begin
                    t = exp_arr[exp_rd];
                    exp_rd++;
                    if (m_wr !== t.wr || m_addr !== t.addr || int'(rem_cnt) != t.rem ||
                        (t.wr && m_wdata !== t.data)) begin
                        errors++;
                        $display("FAIL bus_txn actual wr=%0d addr=%0h data=%0h rem=%0d required wr=%0d addr=%0h data=%0h rem=%0d",
                                 m_wr, m_addr, m_wdata, rem_cnt, t.wr, t.addr, t.data, t.rem);
                    end
                end
                if (m_wr) mem[m_addr] = m_wdata;
            end
        end
        prev_stall = reset_n && m_req && !m_grant;
        prev_bus   = {m_req, m_wr, m_addr, m_wdata};
    end

    // FIFO and bus responder, driven just after the active edge.
    int served     = 0;
    int words_out  = 0;
    int seen_txns  = 0;
    int stall_left = 0;
    int pidx;
    initial begin
        fifo_rd_ack     = 1'b0;
        fifo_rd_err     = 1'b0;
        fifo_dout       = 32'd0;
        fifo_data_count = 5'd0;
        m_grant         = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            fifo_rd_ack = 1'b0;
            fifo_rd_err = 1'b0;
            fifo_dout   = 32'd0;
            if (pops > served) begin
                pidx = served;
                served++;
                if (pidx == fault_pop) begin
                    fifo_rd_err = 1'b1;
                end else if (pidx == fault_pop + 1) begin
                    // no response at all
                end else if (words_out < n_pushed) begin
                    fifo_rd_ack = 1'b1;
                    fifo_dout   = wbuf[words_out];
                    words_out++;
                end else begin
                    fifo_rd_err = 1'b1;
                end
            end
            fifo_data_count = 5'(n_pushed - words_out);
            if (txns != seen_txns) begin
                seen_txns  = txns;
                stall_left = rand_mode ? int'($urandom_range(0, 5)) : 0;
            end
            if (!m_req) begin
                m_grant = 1'b0;
            end else if (stall_left == 0) begin
                m_grant = 1'b1;
            end else begin
                m_grant = 1'b0;
                stall_left--;
            end
        end
    end

    task automatic push_word(input logic [31:0] w);
        wbuf[n_pushed] = w;
        n_pushed++;
    endtask

    // Reference: sequential word copy with wrapping addresses.
    task automatic model_desc(input logic [7:0] src, input logic [7:0] dst, input logic [15:0] size);
        logic [7:0]  ra;
        logic [7:0]  wa;
        logic [31:0] d;
        for (int k = 0; k < int'(size); k++) begin
            ra = src + 8'(k);
            wa = dst + 8'(k);
            d  = model_mem[ra];
            exp_arr[exp_wr] = '{1'b0, ra, 32'd0, int'(size) - k};
            exp_wr++;
            exp_arr[exp_wr] = '{1'b1, wa, d, int'(size) - k};
            exp_wr++;
            model_mem[wa] = d;
        end
    endtask

    int   p0, d0, t0, cyc, mism;
    vec_t v;
    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        vecs[0] = '{8'h10, 8'h80, 16'd3, 3, 6,  1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h05, 8'h20, 16'd0, 3, 0,  1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'hFE, 8'hFF, 16'd3, 3, 6,  1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h30, 8'h50, 16'd5, 5, 10, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{8'h40, 8'h41, 16'd4, 3, 8,  1'b0, 1'b0, 1'b1};
        for (int i = 5; i < 9; i++) begin
            vecs[i].src        = 8'($urandom_range(0, 255));
            vecs[i].dst        = 8'($urandom_range(0, 255));
            vecs[i].size       = 16'($urandom_range(1, 6));
            vecs[i].exp_pops   = 3;
            vecs[i].exp_txns   = 2 * int'(vecs[i].size);
            vecs[i].faults     = 1'b0;
            vecs[i].drop_en    = 1'b0;
            vecs[i].rand_grant = 1'b1;
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_bus", {m_req, m_wr, m_addr, m_wdata}, 0);
        check("rst_rem", rem_cnt, 0);
        for (int i = 0; i < 256; i++) model_mem[i] = mem[i];
        reset_n = 1'b1;
        en      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);

        for (int i = 0; i < 9; i++) begin
            v         = vecs[i];
            rand_mode = v.rand_grant;
            p0 = pops;
            d0 = dones;
            t0 = txns;
            if (v.faults) fault_pop = p0 + 1;
            model_desc(v.src, v.dst, v.size);
            push_word({24'h0, v.src});
            push_word({24'h0, v.dst});
            if (i == 0) begin
                repeat (10) @(posedge clk);
                #1;
                check("partial_no_pop", pops, p0);
                check("partial_idle", busy, 0);
            end
            push_word({16'h0, v.size});
            if (!en) begin
                repeat (8) @(posedge clk);
                #1;
                check("en_gate_no_pop", pops, p0);
                check("en_gate_idle", busy, 0);
                en = 1'b1;
            end
            cyc = 0;
            while (dones == d0 && cyc < 500) begin
                @(posedge clk);
                #1;
                cyc++;
                if (v.drop_en && txns > t0) en = 1'b0;
            end
            repeat (3) @(posedge clk);
            #1;
            check("done_once", dones, d0 + 1);
            check("pop_count", pops, p0 + v.exp_pops);
            check("txn_count", txns, t0 + v.exp_txns);
            check("exp_drained", exp_rd, exp_wr);
            check("back_idle", busy, 0);
            check("rem_zero", rem_cnt, 0);
        end

        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== model_mem[i]) mism++;
        check("final_mem", mism, 0);

        // Reset asserted in the first read cycle of a descriptor.
        rand_mode = 1'b0;
        model_desc(8'h60, 8'h70, 16'd4);
        push_word(32'h60);
        push_word(32'h70);
        push_word(32'd4);
        cyc = 0;
        while (!(m_req && !m_wr) && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("reached_rd", {m_req, m_wr}, 2'b10);
        reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_bus", {m_req, m_wr, m_addr, m_wdata}, 0);
        check("abort_misc", {done, fifo_rd_en, rem_cnt}, 0);
        repeat (2) @(posedge clk);
        exp_rd = exp_wr;
        d0 = dones;
        #1;
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("no_done_after_abort", dones, d0);
        check("idle_after_abort", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
